break_value_scanner: RTL and testbench

//  WalkSAT producer stage, sitting upstream of the heuristic selector. Accepts one unsatisfied clause
//  (NSAT variable ids + enable bits), walks each variable's clause-occurrence list in occurrence memory
//  and counts break values. Break = clauses that become unsat if the variable flips.

---
 rtl/sat_pkg.sv | 24 ++
 rtl/break_value_scanner_lfsr32.sv | 26 ++
 rtl/break_value_scanner.sv | 167 ++++++++++++++++
 tb/tb_break_value_scanner.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared definitions for the WalkSAT break-value scanner: scanner states,
// LFSR constants, default sizing and a width helper.
package sat_pkg;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2357;

  localparam int MC_DEFAULT       = 20;
  localparam int NSAT_DEFAULT     = 3;
  localparam int NUM_VARS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EVAL,
    DONE
  } state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/break_value_scanner_lfsr32.sv
// 32-bit Galois LFSR, right-shifting, advancing every clock. The seed is
// loaded while reset is high and must be nonzero.
module lfsr32
  import sat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed_i,
  output logic [31:0] value_o
);

  logic [31:0] lfsr_q;

  // Shift right each cycle; fold the taps back in when a one falls out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= seed_i;
    end else begin
      // NOTE: registers are written with <= so every flop samples pre-edge values.
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/break_value_scanner.sv
// WalkSAT break-value scanner. Takes one unsatisfied clause, walks each
// enabled variable's occurrence list and counts clauses that would become
// unsatisfied if that variable flipped. Optional macro BREAK_EARLY_EXIT_EN
// stops the scan as soon as one variable finishes with a zero break value.
module break_value_scanner
  import sat_pkg::*;
#(
  parameter int          MAX_CLAUSES_PER_VARIABLE = MC_DEFAULT,
  parameter int          NSAT                     = NSAT_DEFAULT,
  parameter int          NUM_VARS                 = NUM_VARS_DEFAULT,
  parameter logic [31:0] SEED                     = SEED_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clause_valid_i,
  output logic                            clause_ready_o,
  input  logic [NSAT*$clog2(NUM_VARS)-1:0] var_ids_i,
  input  logic [NSAT-1:0]                 var_en_i,
  output logic                            occ_rd_en_o,
  output logic [$clog2(NUM_VARS)+$clog2(MAX_CLAUSES_PER_VARIABLE)-1:0] occ_rd_addr_o,
  input  logic                            occ_valid_i,
  input  logic                            occ_lit_true_i,
  input  logic [$clog2(NSAT+1)-1:0]       occ_true_count_i,
  output logic [NSAT*$clog2(MAX_CLAUSES_PER_VARIABLE)-1:0] break_values_o,
  output logic [NSAT-1:0]                 break_values_valid_o,
  output logic [31:0]                     random_o,
  output logic                            result_valid_o,
  input  logic                            result_ready_i,
  output logic                            busy_o
);

  localparam int MC  = MAX_CLAUSES_PER_VARIABLE;
  localparam int MCB = $clog2(MC);
  localparam int VB  = $clog2(NUM_VARS);
  localparam int TCW = $clog2(NSAT + 1);
  localparam int KB  = idx_width(NSAT);
  localparam logic [MCB-1:0] CNT_MAX   = {MCB{1'b1}};
  localparam logic [MCB-1:0] SLOT_LAST = MCB'(MC - 1);

  state_e                     state_q;
  logic [NSAT-1:0][VB-1:0]    ids_q;
  logic [NSAT-1:0]            en_q;
  logic [KB-1:0]              k_q;
  logic [MCB-1:0]             slot_q;
  logic [NSAT-1:0][MCB-1:0]   cnt_q;
  logic [NSAT-1:0]            valid_q;
  logic [31:0]                random_q;
  logic                       result_valid_q;

  logic [31:0]    lfsr_value;
  logic [KB-1:0]  first_k, next_k;
  logic           first_found, next_found;
  logic           crit_hit, var_end, stop_early;
  logic [MCB-1:0] cnt_cur, cnt_d;

  lfsr32 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed_i (SEED),
    .value_o(lfsr_value)
  );

  // Lowest enabled literal of the offered clause, and the next enabled
  // literal above the one currently being scanned.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    first_k     = '0;
    first_found = 1'b0;
    next_k      = '0;
    next_found  = 1'b0;
    for (int j = NSAT - 1; j >= 0; j--) begin
      if (var_en_i[j]) begin
        first_k     = KB'(j);
        first_found = 1'b1;
      end
      if (en_q[j] && (j > int'(k_q))) begin
        next_k     = KB'(j);
        next_found = 1'b1;
      end
    end
  end

  // Saturating break counter update from the occurrence read data.
  always_comb begin
    crit_hit = occ_valid_i && occ_lit_true_i && (occ_true_count_i == TCW'(1));
    cnt_cur  = cnt_q[k_q];
    cnt_d    = (crit_hit && (cnt_cur != CNT_MAX)) ? cnt_cur + 1'b1 : cnt_cur;
    var_end  = !occ_valid_i || (slot_q == SLOT_LAST);
  end

`ifdef BREAK_EARLY_EXIT_EN
  // A finished variable with no breaks is the selector's pick already.
  assign stop_early = (cnt_d == '0);
`else
  assign stop_early = 1'b0;
`endif

  // Scanner FSM: latch clause, alternate READ/EVAL per slot, hold result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the latched clause is a handful of flops, so it is reset like any other state.
      state_q        <= IDLE;
      ids_q          <= '0;
      en_q           <= '0;
      k_q            <= '0;
      slot_q         <= '0;
      cnt_q          <= '0;
      valid_q        <= '0;
      random_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clause_valid_i) begin
            ids_q   <= var_ids_i;
            en_q    <= var_en_i;
            cnt_q   <= '0;
            valid_q <= '0;
            slot_q  <= '0;
            k_q     <= first_k;
            state_q <= first_found ? READ : DONE;
          end
        end
        READ: state_q <= EVAL;
        EVAL: begin
          cnt_q[k_q] <= cnt_d;
          if (var_end) begin
            valid_q[k_q] <= 1'b1;
            slot_q       <= '0;
            if (stop_early || !next_found) begin
              state_q        <= DONE;
              result_valid_q <= 1'b1;
              random_q       <= lfsr_value;
            end else begin
              k_q     <= next_k;
              state_q <= READ;
            end
          end else begin
            slot_q  <= slot_q + 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          // An empty clause arrives here straight from IDLE; publish one cycle later.
          if (!result_valid_q) begin
            result_valid_q <= 1'b1;
            random_q       <= lfsr_value;
          end else if (result_ready_i) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clause_ready_o       = (state_q == IDLE);
  assign busy_o               = (state_q != IDLE);
  assign occ_rd_en_o          = (state_q == READ);
  assign occ_rd_addr_o        = occ_rd_en_o ? {ids_q[k_q], slot_q} : '0;
  assign break_values_o       = cnt_q;
  assign break_values_valid_o = valid_q;
  assign random_o             = random_q;
  assign result_valid_o       = result_valid_q;

endmodule

// File: tb/tb_break_value_scanner.sv
// Scoreboard bench for break_value_scanner (MC=16, NSAT=3, 1024 vars).
// Expectations are pushed when a clause is issued; a negedge monitor pops
// and compares whenever result_valid_o rises and while it is held.
module tb_break_value_scanner;

  localparam int MC   = 16;
  localparam int MCB  = 4;
  localparam int NSAT = 3;
  localparam int VB   = 10;
  localparam int AW   = VB + MCB;
  localparam logic [31:0] SEED = 32'hACE1_2357;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef struct {
    logic [NSAT*MCB-1:0] values;
    logic [NSAT-1:0]     valid;
    int                  lat;
    int                  reads;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clause_valid_i = 1'b0;
  logic                 clause_ready_o;
  logic [NSAT*VB-1:0]   var_ids_i = '0;
  logic [NSAT-1:0]      var_en_i = '0;
  logic                 occ_rd_en_o;
  logic [AW-1:0]        occ_rd_addr_o;
  logic                 occ_valid_i = 1'b0;
  logic                 occ_lit_true_i = 1'b0;
  logic [1:0]           occ_true_count_i = '0;
  logic [NSAT*MCB-1:0]  break_values_o;
  logic [NSAT-1:0]      break_values_valid_o;
  logic [31:0]          random_o;
  logic                 result_valid_o;
  logic                 result_ready_i = 1'b1;
  logic                 busy_o;

  break_value_scanner #(
    .MAX_CLAUSES_PER_VARIABLE(MC),
    .NSAT                    (NSAT),
    .NUM_VARS                (1024),
    .SEED                    (SEED)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clause_valid_i      (clause_valid_i),
    .clause_ready_o      (clause_ready_o),
    .var_ids_i           (var_ids_i),
    .var_en_i            (var_en_i),
    .occ_rd_en_o         (occ_rd_en_o),
    .occ_rd_addr_o       (occ_rd_addr_o),
    .occ_valid_i         (occ_valid_i),
    .occ_lit_true_i      (occ_lit_true_i),
    .occ_true_count_i    (occ_true_count_i),
    .break_values_o      (break_values_o),
    .break_values_valid_o(break_values_valid_o),
    .random_o            (random_o),
    .result_valid_o      (result_valid_o),
    .result_ready_i      (result_ready_i),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;
  int   rd_cnt = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] cur_rand;
  logic [31:0] model, model_prev;
  logic prev_rv = 1'b0;
  logic [3:0] occ_mem [0:(1<<AW)-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] s;
    s = {1'b0, v[31:1]};
    if (v[0]) s = s ^ TAPS;
    return s;
  endfunction

  // Reference LFSR, tracking the value it held before the latest edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model      <= SEED;
      model_prev <= '0;
    end else begin
      model_prev <= model;
      model      <= lfsr_step(model);
    end
  end

  // Occurrence memory with one cycle of read latency.
  always @(posedge clk) begin
    if (occ_rd_en_o) begin
      {occ_valid_i, occ_lit_true_i, occ_true_count_i} <= occ_mem[occ_rd_addr_o];
    end
  end

  // Cycle counter, accept timestamp and read counter (pre-edge samples).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (clause_valid_i && clause_ready_o) begin
      acc_cyc = cyc;
      rd_cnt  = 0;
    end
    if (occ_rd_en_o) rd_cnt = rd_cnt + 1;
  end

  // Monitor: compare on result rise and while the result is held.
  always @(negedge clk) begin
    if (reset) begin
      prev_rv = 1'b0;
    end else begin
      if (result_valid_o) begin
        if (!prev_rv) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got result_valid 1 expected no result (t=%0t)", $time);
            cur.values = '0; cur.valid = '0; cur.lat = 0; cur.reads = 0;
          end else begin
            cur = exp_q.pop_front();
            check("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
            check("read_count", 64'(rd_cnt), 64'(cur.reads));
          end
          cur_rand = model_prev;
        end
        check("break_values", 64'(break_values_o), 64'(cur.values));
        check("break_valid", 64'(break_values_valid_o), 64'(cur.valid));
        check("random", 64'(random_o), 64'(cur_rand));
        check("ready_while_done", 64'(clause_ready_o), 64'd0);
      end else if (prev_rv) begin
        check("ready_after_handshake", 64'(clause_ready_o), 64'd1);
      end
      prev_rv = result_valid_o;
    end
  end

  function automatic logic [NSAT*VB-1:0] pack_ids(input int a, input int b, input int c);
    return {VB'(c), VB'(b), VB'(a)};
  endfunction

  function automatic exp_t mk(input logic [NSAT*MCB-1:0] v, input logic [NSAT-1:0] vl,
                              input int lat, input int reads);
    exp_t e;
    e.values = v; e.valid = vl; e.lat = lat; e.reads = reads;
    return e;
  endfunction

  task automatic set_slot(input int vid, input int slot, input logic v, input logic t,
                          input logic [1:0] tc);
    occ_mem[vid * MC + slot] = {v, t, tc};
  endtask

  // Offer a clause (called at a negedge) and hold it until accepted.
  task automatic send(input logic [NSAT*VB-1:0] ids, input logic [NSAT-1:0] en,
                      input bit push, input exp_t e);
    int n;
    if (push) exp_q.push_back(e);
    var_ids_i      = ids;
    var_en_i       = en;
    clause_valid_i = 1'b1;
    n = 0;
    while (!clause_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!clause_ready_o) check("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    clause_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !clause_ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got busy expected idle", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int snap;
    exp_t none;
    none = mk('0, '0, 0, 0);
    for (int i = 0; i < (1 << AW); i++) occ_mem[i] = 4'b0;

    // Occurrence lists ({valid, lit_true, true_count}); unset slots end the list.
    set_slot(5, 0, 1, 1, 1); set_slot(5, 1, 1, 1, 2); set_slot(5, 2, 1, 1, 1);
    for (int s = 0; s < MC; s++) set_slot(20, s, 1, 1, 1);
    set_slot(30, 0, 1, 1, 1); set_slot(30, 1, 1, 0, 1);
    set_slot(40, 0, 1, 1, 1);
    set_slot(42, 0, 1, 1, 1); set_slot(42, 1, 1, 1, 1); set_slot(42, 2, 1, 1, 3);
    set_slot(51, 0, 1, 1, 1);
    set_slot(60, 0, 1, 1, 1);
    set_slot(61, 0, 1, 1, 1); set_slot(61, 1, 1, 1, 1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_result_valid", 64'(result_valid_o), 64'd0);
    check("rst_break_values", 64'(break_values_o), 64'd0);
    check("rst_break_valid", 64'(break_values_valid_o), 64'd0);
    check("rst_random", 64'(random_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rd_en", 64'(occ_rd_en_o), 64'd0);
    check("rst_rd_addr", 64'(occ_rd_addr_o), 64'd0);
    check("rst_clause_ready", 64'(clause_ready_o), 64'd1);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_no_reads", 64'(rd_cnt), 64'd0);
    check("idle_ready", 64'(clause_ready_o), 64'd1);

    // Two literals, mixed critical/non-critical slots: K=5.
    send(pack_ids(5, 9, 13), 3'b011, 1'b1, mk(12'h002, 3'b011, 10, 5));
    wait_idle("basic");

    // No literal enabled: result one cycle after accept.
    send(pack_ids(1, 2, 3), 3'b000, 1'b1, mk(12'h000, 3'b000, 1, 0));
    wait_idle("empty");

    // Disabled middle literal skipped; true_count=3 slot not counted: K=6.
    send(pack_ids(40, 41, 42), 3'b101, 1'b1, mk(12'h201, 3'b101, 12, 6));
    wait_idle("skip");

    // Full 16-slot list, all critical: saturates at 15, no 17th read.
    send(pack_ids(20, 21, 22), 3'b001, 1'b1, mk(12'h00F, 3'b001, 32, 16));
    wait_idle("saturate");

    // Backpressure: ready held low 5 cycles after result_valid_o.
    result_ready_i = 1'b0;
    send(pack_ids(30, 31, 32), 3'b001, 1'b1, mk(12'h001, 3'b001, 6, 3));
    n = 0;
    while (!result_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_result_seen", 64'(result_valid_o), 64'd1);
    repeat (5) @(negedge clk);
    result_ready_i = 1'b1;
    wait_idle("backpressure");

    // Reset pulsed while evaluating var1's first slot.
    send(pack_ids(60, 61, 62), 3'b011, 1'b0, none);
    n = 0;
    while (!(occ_rd_en_o && occ_rd_addr_o == AW'(61 * MC)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_var1", 64'(occ_rd_addr_o), 64'(61 * MC));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_result_valid", 64'(result_valid_o), 64'd0);
    check("mid_rst_break_values", 64'(break_values_o), 64'd0);
    check("mid_rst_break_valid", 64'(break_values_valid_o), 64'd0);
    check("mid_rst_rd_en", 64'(occ_rd_en_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_ready", 64'(clause_ready_o), 64'd1);
    reset = 1'b0;
    snap = rd_cnt;
    repeat (6) @(negedge clk);
    check("post_rst_no_reads", 64'(rd_cnt), 64'(snap));
    check("post_rst_no_result", 64'(result_valid_o), 64'd0);
    send(pack_ids(5, 9, 13), 3'b011, 1'b1, mk(12'h002, 3'b011, 10, 5));
    wait_idle("post_reset");

    // First literal has an empty list.
`ifdef BREAK_EARLY_EXIT_EN
    send(pack_ids(50, 51, 52), 3'b111, 1'b1, mk(12'h000, 3'b001, 2, 1));
`else
    send(pack_ids(50, 51, 52), 3'b111, 1'b1, mk(12'h010, 3'b111, 8, 4));
`endif
    wait_idle("early_exit");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
